shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have parameter: WIDTH, 8, word length in bits (legal range 2..32).
REQ-002 The block SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 The block SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port: pi  input  WIDTH  parallel word to transmit.
REQ-005 The block SHALL have port: pi_valid  input  1  pi holds a word to accept.
REQ-006 The block SHALL have port: pi_ready  output  1  block can accept a word this cycle.
REQ-007 The block SHALL have port: si  input  1  serial data in, captured at LSB.
REQ-008 The block SHALL have port: hold  input  1  stall shifting while high.
REQ-009 The block SHALL have port: so  output  1  serial data out, MSB first.
REQ-010 The block SHALL have port: so_valid  output  1  so carries a valid bit this cycle.
REQ-011 The block SHALL have port: po  output  WIDTH  last fully captured serial-in word.
REQ-012 The block SHALL have port: po_valid  output  1  one-cycle pulse, po updated.
REQ-013 The block SHALL have port: busy  output  1  a transfer is in progress.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-015 pi_ready SHALL be 1 in IDLE and DONE, and 0 in SHIFT.
REQ-016 Accept SHALL occur when pi_valid and pi_ready are both 1 at a rising edge; on accept, pi is loaded into the shift register, the bit counter is cleared, and the next state is SHIFT.
REQ-017 In SHIFT with hold=0, so SHALL equal register MSB, so_valid SHALL be 1, and at the edge the register shifts left with si entering the LSB and the counter increments.
REQ-018 In SHIFT with hold=1, so_valid SHALL be 0 and the register and counter SHALL be frozen; hold SHALL have no effect in IDLE or DONE.
REQ-019 When the counter reaches WIDTH-1 and hold=0, the next state SHALL be DONE; hold=1 on that cycle SHALL take priority and keep the state in SHIFT.
REQ-020 In DONE, po SHALL take the register contents (all WIDTH captured si bits) and po_valid SHALL be 1 for exactly that cycle.
REQ-021 DONE SHALL last one cycle and then go to SHIFT if an accept occurs, otherwise to IDLE.
REQ-022 Latency SHALL be: accept at edge k gives bits on cycles k+1..k+WIDTH when no hold is applied, and po_valid on cycle k+WIDTH+1.
REQ-023 Back-to-back words SHALL have a gap of exactly one so_valid=0 cycle between them.
REQ-024 pi and pi_valid SHALL be ignored in SHIFT; no word is queued.
REQ-025 so SHALL be 0 whenever so_valid=0.
REQ-026 busy SHALL be 1 in SHIFT and DONE.
REQ-027 po SHALL hold its value between DONE cycles.
REQ-028 The counter SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1.

Reset
REQ-029 rst=0 SHALL immediately force the state to IDLE and clear the register, counter and po to 0.
REQ-030 While rst=0, so, so_valid, po_valid and busy SHALL be 0 and pi_ready SHALL be 1.
REQ-031 Reset during SHIFT SHALL abort the transfer with no po_valid pulse; the first accept after release SHALL start a fresh word.

Structure
REQ-032 Package shift_seq_pkg SHALL hold the state enum (IDLE, SHIFT, DONE) and DEFAULT_WIDTH=8.
REQ-033 The block SHALL use one sub-module, shift_reg_core: WIDTH-bit register with parallel load, shift enable, serial in at LSB, MSB out, and async active-low clear.
REQ-034 The FSM and counter SHALL live in shift_sequencer.

Verification
REQ-035 The bench SHALL check: pi=8'b10010100 accepted, hold=0 -> so=1,0,0,1,0,1,0,0 on 8 consecutive so_valid cycles.
REQ-036 The bench SHALL check: si driving 0xA5 MSB-first during a transfer -> po=0xA5 with po_valid high one cycle at k+9.
REQ-037 The bench SHALL check: hold=1 for 3 cycles after the 3rd bit -> so_valid low 3 cycles, same bit sequence, po_valid at k+12.
REQ-038 The bench SHALL check: rst=0 after the 4th bit -> outputs zero at once, po stays 0, no po_valid, pi_ready=1 after release.
REQ-039 The bench SHALL check: pi_valid held with 0xFF then 0x00 -> eight 1s, one idle cycle, eight 0s, pi_ready low throughout SHIFT.
REQ-040 The bench SHALL check: pi changed to 0x3C with pi_valid=1 mid-SHIFT -> the in-flight word is unchanged and 0x3C is accepted only in DONE.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the shift sequencer.
package shift_seq_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/shift_sequencer_core.sv
// WIDTH-bit shift register with parallel load, serial in at LSB and MSB out.
module shift_reg_core #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_shift,
   input  logic             i_si,
   output logic             o_msb,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   // Parallel load wins over shift; serial data enters at the LSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_data;
      end else if (i_shift) begin
         r_q <= {r_q[WIDTH-2:0], i_si};
      end
   end

   assign o_msb = r_q[WIDTH-1];
   assign o_q   = r_q;

endmodule

// File: rtl/shift_sequencer.sv
// Parallel-in/serial-out transmitter with simultaneous serial-in/parallel-out capture.
module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pi,
   input  logic             pi_valid,
   output logic             pi_ready,
   input  logic             si,
   input  logic             hold,
   output logic             so,
   output logic             so_valid,
   output logic [WIDTH-1:0] po,
   output logic             po_valid,
   output logic             busy
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_po;
   logic [WIDTH-1:0] w_q;
   logic             w_msb;
   logic             w_accept;
   logic             w_shift;
   logic             w_last;

   shift_reg_core #(.WIDTH(WIDTH)) u_core (
      .clk     (clk),
      .rst_n   (rst),
      .i_load  (w_accept),
      .i_data  (pi),
      .i_shift (w_shift),
      .i_si    (si),
      .o_msb   (w_msb),
      .o_q     (w_q)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   // Next state and handshake/serial outputs; hold only matters in SHIFT.
   always_comb begin
      w_next   = r_state;
      pi_ready = 1'b0;
      so       = 1'b0;
      so_valid = 1'b0;
      po_valid = 1'b0;
      busy     = 1'b0;
      w_accept = 1'b0;
      w_shift  = 1'b0;
      w_last   = 1'b0;
      case (r_state)
         IDLE: begin
            pi_ready = 1'b1;
            w_accept = pi_valid;
            if (pi_valid) w_next = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (!hold) begin
               so       = w_msb;
               so_valid = 1'b1;
               w_shift  = 1'b1;
               if (r_cnt == CNT_W'(WIDTH - 1)) begin
                  w_last = 1'b1;
                  w_next = DONE;
               end
            end
         end
         DONE: begin
            pi_ready = 1'b1;
            busy     = 1'b1;
            po_valid = 1'b1;
            w_accept = pi_valid;
            w_next   = pi_valid ? SHIFT : IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Bit counter saturates at WIDTH-1 on the final shift; cleared on accept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= '0;
      end else if (w_shift && !w_last) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Capture the completed word on the edge into DONE so po is valid with po_valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_po <= '0;
      end else if (w_last) begin
         r_po <= {w_q[WIDTH-2:0], si};
      end
   end

   assign po = r_po;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench: stimulus queues expected serial bits and po words, a monitor checks them.
module tb_shift_sequencer;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [W-1:0] pi = '0;
   logic         pi_valid = 1'b0;
   logic         pi_ready;
   logic         si = 1'b0;
   logic         hold = 1'b0;
   logic         so;
   logic         so_valid;
   logic [W-1:0] po;
   logic         po_valid;
   logic         busy;

   typedef struct {
      int           cyc;
      logic [W-1:0] val;
   } exp_t;

   exp_t         exp_bits[$];
   exp_t         exp_po[$];
   int           n_pass = 0;
   int           n_total = 0;
   int           n_edge = 0;
   logic [W-1:0] po_hold = '0;
   bit           mon_en = 1'b0;

   shift_sequencer #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .pi       (pi),
      .pi_valid (pi_valid),
      .pi_ready (pi_ready),
      .si       (si),
      .hold     (hold),
      .so       (so),
      .so_valid (so_valid),
      .po       (po),
      .po_valid (po_valid),
      .busy     (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) n_edge++;

   task automatic check(input bit ok, input string name, input int act, input int exp);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, n_edge + 1);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: cycle number is one more than the count of rising edges seen so far.
   always @(negedge clk) begin
      if (mon_en && rst) begin
         if (so_valid) begin
            if (exp_bits.size() == 0) begin
               check(1'b0, "so_unexpected", int'(so), 0);
            end else begin
               exp_t e;
               e = exp_bits.pop_front();
               check(so == e.val[0], "so_bit", int'(so), int'(e.val[0]));
               check(n_edge + 1 == e.cyc, "so_cycle", n_edge + 1, e.cyc);
            end
         end else begin
            check(so == 1'b0, "so_idle_zero", int'(so), 0);
         end
         if (po_valid) begin
            if (exp_po.size() == 0) begin
               check(1'b0, "po_valid_unexpected", int'(po), 0);
            end else begin
               exp_t e;
               e = exp_po.pop_front();
               check(po == e.val, "po_word", int'(po), int'(e.val));
               check(n_edge + 1 == e.cyc, "po_cycle", n_edge + 1, e.cyc);
               po_hold = e.val;
            end
         end else begin
            check(po == po_hold, "po_held", int'(po), int'(po_hold));
         end
      end
   end

   // One word: accept, W serial cycles (with optional hold window), then the DONE cycle.
   task automatic xfer(input logic [W-1:0] w, input logic [W-1:0] s, input int hstart,
                       input int hlen, input bit nv, input logic [W-1:0] nw);
      int k, c, sent, held;
      pi       = w;
      pi_valid = 1'b1;
      step();
      k        = n_edge;
      pi_valid = nv;
      c        = k + 1;
      sent     = 0;
      held     = 0;
      while (sent < int'(W)) begin
         check(pi_ready == 1'b0, "pi_ready_shift", int'(pi_ready), 0);
         check(busy == 1'b1, "busy_shift", int'(busy), 1);
         if (nv && sent == 4) pi = nw;
         if (sent == hstart && held < hlen) begin
            hold = 1'b1;
            held++;
         end else begin
            hold = 1'b0;
            si   = s[W-1-sent];
            exp_bits.push_back('{c, W'(w[W-1-sent])});
            sent++;
         end
         step();
         c++;
      end
      hold = 1'b0;
      si   = 1'b0;
      exp_po.push_back('{c, s});
      check(pi_ready == 1'b1, "pi_ready_done", int'(pi_ready), 1);
      check(busy == 1'b1, "busy_done", int'(busy), 1);
   endtask

   initial begin
      logic [W-1:0] w;
      int k;
      #1;
      check(pi_ready == 1'b1, "rst_pi_ready", int'(pi_ready), 1);
      check(so_valid == 1'b0, "rst_so_valid", int'(so_valid), 0);
      check(so == 1'b0, "rst_so", int'(so), 0);
      check(busy == 1'b0, "rst_busy", int'(busy), 0);
      check(po_valid == 1'b0, "rst_po_valid", int'(po_valid), 0);
      check(po == '0, "rst_po", int'(po), 0);
      step();
      step();
      rst    = 1'b1;
      mon_en = 1'b1;
      step();

      // 10010100 out, 0xA5 in, no hold: po at k+9.
      xfer(8'b10010100, 8'hA5, 99, 0, 1'b0, 8'h00);
      step();
      check(busy == 1'b0, "idle_busy", int'(busy), 0);
      check(pi_ready == 1'b1, "idle_pi_ready", int'(pi_ready), 1);
      step();

      // Three hold cycles after the third bit: po at k+12.
      xfer(8'h5A, 8'h3C, 3, 3, 1'b0, 8'h00);
      step();
      step();

      // Reset after the fourth bit aborts the word.
      w        = 8'hC3;
      pi       = w;
      pi_valid = 1'b1;
      step();
      k        = n_edge;
      pi_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         si = 1'b1;
         exp_bits.push_back('{k + 1 + i, W'(w[W-1-i])});
         step();
      end
      rst = 1'b0;
      #1;
      po_hold = '0;
      check(so == 1'b0, "abort_so", int'(so), 0);
      check(so_valid == 1'b0, "abort_so_valid", int'(so_valid), 0);
      check(busy == 1'b0, "abort_busy", int'(busy), 0);
      check(po_valid == 1'b0, "abort_po_valid", int'(po_valid), 0);
      check(po == '0, "abort_po", int'(po), 0);
      check(pi_ready == 1'b1, "abort_pi_ready", int'(pi_ready), 1);
      step();
      step();
      rst = 1'b1;
      #1;
      check(pi_ready == 1'b1, "release_pi_ready", int'(pi_ready), 1);
      check(busy == 1'b0, "release_busy", int'(busy), 0);
      step();

      // pi_valid held: 0xFF then 0x00 back to back, one gap cycle.
      xfer(8'hFF, 8'h0F, 99, 0, 1'b1, 8'h00);
      xfer(8'h00, 8'hF0, 99, 0, 1'b0, 8'h00);
      step();

      // 0x3C presented mid-shift is taken only at DONE.
      xfer(8'h81, 8'h66, 99, 0, 1'b1, 8'h3C);
      xfer(8'h3C, 8'h99, 99, 0, 1'b0, 8'h00);
      step();
      step();
      step();

      check(exp_bits.size() == 0, "bits_drained", exp_bits.size(), 0);
      check(exp_po.size() == 0, "po_drained", exp_po.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
